// File: rtl/pwl_sample_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for sampling pwl waveforms on a clock edge.
// Simulation time is reported in seconds; the time unit of this file is 1 ns.
package pwl_sample_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  // pwl segment: value a at time t0, slope b in units per second
  typedef struct {
    real a;
    real b;
    real t0;
  } pwl;

  function automatic real get_tnow();
    return $realtime * 1.0e-9;
  endfunction

  function automatic real eval_pwl(pwl p, real t);
    return p.a + p.b * (t - p.t0);
  endfunction

endpackage

// File: rtl/pwl_sample_avg.sv
`timescale 1ns/1ps
// Boxcar decimator: averages N edge-sampled pwl values, presents the mean on valid/ready.
// Define PWL_SAMPLE_AVG_CLAMP_EN to clamp samples to [VMIN, VMAX] and raise the sticky clip flag.
module pwl_sample_avg
  import pwl_sample_pkg::*;
#(
  parameter int  N    = 4,
  parameter real VMIN = -1.0e3,
  parameter real VMAX = 1.0e3
) (
  input  logic             clk,
  input  logic             rst,
  input  pwl               in_val,
  input  logic             en,
  output real              out_avg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             clip,
  output logic [CNT_W-1:0] win_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state_q;
  real              acc_q;
  real              avg_q;
  logic             valid_q;
  logic             ovr_q;
  logic [CNT_W-1:0] cnt_q;

  // Evaluated inside the edge-triggered blocks so tnow is the edge time.
  function automatic real raw_sample();
    return eval_pwl(in_val, get_tnow());
  endfunction

  function automatic logic in_range(real s);
    return (s >= VMIN) && (s <= VMAX);
  endfunction

  function automatic real shape(real s);
`ifdef PWL_SAMPLE_AVG_CLAMP_EN
    if (s > VMAX) return VMAX;
    if (s < VMIN) return VMIN;
`endif
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 0.0;
      avg_q   <= 0.0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // A transfer drops valid unless a completion below reloads it.
      if (valid_q && out_ready) valid_q <= 1'b0;

      if (!en) begin
        if (state_q == ACCUM) begin
          acc_q   <= 0.0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      end else begin
        state_q <= ACCUM;
        if (cnt_q == LAST) begin
          acc_q <= 0.0;
          cnt_q <= '0;
          if (valid_q && !out_ready) begin
            ovr_q <= 1'b1;
          end else begin
            avg_q   <= (acc_q + shape(raw_sample())) / real'(N);
            valid_q <= 1'b1;
          end
        end else begin
          acc_q <= acc_q + shape(raw_sample());
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef PWL_SAMPLE_AVG_CLAMP_EN
  logic clip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                clip_q <= 1'b0;
    else if (en && !in_range(raw_sample())) clip_q <= 1'b1;
  end

  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif

  assign out_avg   = avg_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign win_cnt   = cnt_q;

endmodule

// File: tb/tb_pwl_sample_avg.sv
`timescale 1ns/1ps
// Randomised bench for pwl_sample_avg: three instances (N=4, N=1, N=4 with +-1 clamp
// bounds) share one stimulus and are compared against a window-queue reference model.
module tb_pwl_sample_avg;
  import pwl_sample_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b1;
  logic rst, en, rdy;
  pwl   in_val;

  real         avg0, avg1, avg2;
  logic        v0, v1, v2, o0, o1, o2, c0, c1, c2;
  logic [15:0] w0, w1, w2;

  always #500 clk = ~clk;

  pwl_sample_avg #(.N(4)) u_n4 (
    .clk(clk), .rst(rst), .in_val(in_val), .en(en), .out_avg(avg0), .out_valid(v0),
    .out_ready(rdy), .overrun(o0), .clip(c0), .win_cnt(w0));
  pwl_sample_avg #(.N(1)) u_n1 (
    .clk(clk), .rst(rst), .in_val(in_val), .en(en), .out_avg(avg1), .out_valid(v1),
    .out_ready(rdy), .overrun(o1), .clip(c1), .win_cnt(w1));
  pwl_sample_avg #(.N(4), .VMIN(-1.0), .VMAX(1.0)) u_clp (
    .clk(clk), .rst(rst), .in_val(in_val), .en(en), .out_avg(avg2), .out_valid(v2),
    .out_ready(rdy), .overrun(o2), .clip(c2), .win_cnt(w2));

  // reference model state
  int  nn [NI];
  real vlo[NI], vhi[NI];
  real m_avg[NI];
  bit  m_v[NI], m_o[NI], m_c[NI];
  real win[NI][$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(string tag, real got, real exp);
    real d;
    n_chk++;
    d = got - exp;
    if (d < 0.0) d = -d;
    if (d <= 1.0e-9 * (1.0 + (exp < 0.0 ? -exp : exp))) n_pass++;
    else $display("FAIL %s got=%g exp=%g", tag, got, exp);
  endtask

  task automatic m_reset(int k);
    m_avg[k] = 0.0;
    m_v[k] = 0; m_o[k] = 0; m_c[k] = 0;
    win[k].delete();
  endtask

  task automatic m_edge(int k);
    real s, sum;
    bit  xfer;
    xfer = m_v[k] && rdy;
    if (!en) begin
      win[k].delete();
      if (xfer) m_v[k] = 0;
      return;
    end
    s = in_val.a + in_val.b * ($realtime * 1.0e-9 - in_val.t0);
`ifdef PWL_SAMPLE_AVG_CLAMP_EN
    if (s > vhi[k]) begin s = vhi[k]; m_c[k] = 1; end
    else if (s < vlo[k]) begin s = vlo[k]; m_c[k] = 1; end
`endif
    win[k].push_back(s);
    if (win[k].size() == nn[k]) begin
      sum = 0.0;
      for (int i = 0; i < win[k].size(); i++) sum += win[k][i];
      win[k].delete();
      if (m_v[k] && !rdy) m_o[k] = 1;
      else begin m_avg[k] = sum / nn[k]; m_v[k] = 1; end
    end else if (xfer) begin
      m_v[k] = 0;
    end
  endtask

  task automatic check_all(string ph);
    for (int k = 0; k < NI; k++) begin
      real a; logic v, o, c; logic [15:0] w;
      case (k)
        0:       begin a = avg0; v = v0; o = o0; c = c0; w = w0; end
        1:       begin a = avg1; v = v1; o = o1; c = c1; w = w1; end
        default: begin a = avg2; v = v2; o = o2; c = c2; w = w2; end
      endcase
      chk($sformatf("%s.u%0d.valid", ph, k), real'(v), real'(m_v[k]));
      chk($sformatf("%s.u%0d.avg", ph, k), a, m_avg[k]);
      chk($sformatf("%s.u%0d.overrun", ph, k), real'(o), real'(m_o[k]));
      chk($sformatf("%s.u%0d.clip", ph, k), real'(c), real'(m_c[k]));
      chk($sformatf("%s.u%0d.win_cnt", ph, k), real'(w), real'(win[k].size()));
    end
  endtask

  // one clock edge: model update, check just after, return at the next falling edge
  task automatic step(string ph);
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) m_reset(k);
      else     m_edge(k);
    end
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  function automatic real rr(real lo, real hi);
    return lo + (hi - lo) * real'($urandom_range(0, 10000)) / 10000.0;
  endfunction

  initial begin
    nn[0] = 4; nn[1] = 1; nn[2] = 4;
    vlo[0] = -1.0e3; vhi[0] = 1.0e3;
    vlo[1] = -1.0e3; vhi[1] = 1.0e3;
    vlo[2] = -1.0;   vhi[2] = 1.0;
    for (int k = 0; k < NI; k++) m_reset(k);

    rst = 1'b1; en = 1'b0; rdy = 1'b0;
    in_val = '{a: 0.0, b: 0.0, t0: 0.0};
    #10;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // constant 0.5 with ready held high
    in_val = '{a: 0.5, b: 0.0, t0: 0.0};
    en = 1'b1; rdy = 1'b1;
    repeat (12) step("const");
    chk("const.avg_abs", avg0, 0.5);

    // ramp of 1 per us: first enabled edge samples 1.0, backpressure for 10 edges
    en = 1'b0;
    step("ramp_idle");
    in_val = '{a: 0.0, b: 1.0e6, t0: ($realtime + 500.0) * 1.0e-9 - 1.0e-6};
    en = 1'b1; rdy = 1'b0;
    repeat (4) step("ramp");
    chk("ramp.first_avg", avg0, 2.5);
    chk("ramp.first_valid", real'(v0), 1.0);
    repeat (6) step("bp");
    chk("bp.held_avg", avg0, 2.5);
    chk("bp.overrun", real'(o0), 1.0);
    rdy = 1'b1;
    step("bp_release");
    chk("bp.release_valid", real'(v0), 0.0);
    chk("bp.overrun_sticky", real'(o0), 1.0);
    repeat (5) step("ramp_tail");

    // reset in the middle of a window
    en = 1'b0;
    step("mid_idle");
    en = 1'b1;
    repeat (2) step("mid_fill");
    #100 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) m_reset(k);
    check_all("mid_rst");
    step("mid_rst_hold");
    rst = 1'b0;
    repeat (4) step("mid_after");
    chk("mid.fresh_valid", real'(v0), 1.0);

    // constant above the clamp bound
    in_val = '{a: 3.0, b: 0.0, t0: 0.0};
    en = 1'b0;
    step("clamp_idle");
    en = 1'b1;
    repeat (4) step("clamp");
`ifdef PWL_SAMPLE_AVG_CLAMP_EN
    chk("clamp.avg", avg2, 1.0);
    chk("clamp.clip", real'(c2), 1.0);
`else
    chk("clamp.avg", avg2, 3.0);
    chk("clamp.clip", real'(c2), 0.0);
`endif

    // randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0)
        in_val = '{a: rr(-2.0, 2.0), b: rr(-1.0e5, 1.0e5),
                   t0: $realtime * 1.0e-9 + rr(-1.0e-5, 1.0e-5)};
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #100 rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) m_reset(k);
        check_all("rnd_rst");
        step("rnd_rst_hold");
        rst = 1'b0;
      end else begin
        step("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
